// File: rtl/tb_data_gen_fifo_chk_pkg.sv
// rtl/tb_data_gen_fifo_chk_pkg.sv - shared FSM encodings, sentinels and pattern byte function
package tb_data_gen_fifo_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GEN        = 2'd1,
        ST_WAIT_EMPTY = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [31:0] NO_ERR_BEAT = 32'hFFFF_FFFF;
    localparam logic [15:0] ERR_SAT     = 16'hFFFF;
    localparam logic [7:0]  MASK_ALL    = 8'hFF;

    // Byte at absolute byte offset within a burst; only the low 8 bits of the sum matter.
    function automatic logic [7:0] pattern_byte(input logic [31:0] burst, input logic [31:0] byte_off);
        logic [31:0] sum;
        sum = burst + byte_off;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/tb_data_gen_fifo_chk_fifo.sv
// rtl/tb_data_gen_fifo_chk_fifo.sv - DEPTH-entry synchronous FIFO with registered 1-cycle read
module tb_data_gen_fifo_chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = rd_data_q;

    // A write into a full FIFO is accepted when the same cycle frees an entry.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/tb_data_gen_fifo_chk.sv
// rtl/tb_data_gen_fifo_chk.sv - burst pattern generator through a FIFO with throttled drain and checker
module tb_data_gen_fifo_chk #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [31:0] size,
    input  logic [31:0] times,
    input  logic [7:0]  drain_mask,
    input  logic        ap_start,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic        ap_done,
    output logic [31:0] beat_count,
    output logic [15:0] err_count,
    output logic [31:0] first_err_beat
);

    import tb_data_gen_fifo_chk_pkg::*;

    localparam int BYTES      = WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    // Shared by the write side and the expected-data side so both follow one definition.
    function automatic logic [WIDTH-1:0] pattern_word(input logic [31:0] burst, input logic [31:0] beat);
        logic [WIDTH-1:0] w;
        logic [31:0]      base;
        base = beat << BYTE_SHIFT;
        w    = '0;
        for (int i = 0; i < BYTES; i++) begin
            w[i*8 +: 8] = pattern_byte(burst, base + 32'(i));
        end
        return w;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] beats_q, beats_d;
    logic [31:0] times_q, times_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] burst_idx_q, burst_idx_d;
    logic [31:0] beat_idx_q, beat_idx_d;
    logic [31:0] exp_idx_q, exp_idx_d;
    logic [2:0]  phase_q, phase_d;
    logic        rd_valid_q, rd_valid_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [31:0] beat_count_q, beat_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic [31:0] first_err_q, first_err_d;

    logic [31:0]      beats_in;
    logic             start_acc;
    logic             burst_end;
    logic             mismatch;
    logic             wr_en, rd_en;
    logic             fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_wr_data, fifo_rd_data;

    assign beats_in  = size >> BYTE_SHIFT;
    assign start_acc = (state_q == ST_IDLE) && ap_start;
    // The last read's compare lands the cycle after rd_en, so wait for it before closing a burst.
    assign burst_end = fifo_empty && !rd_valid_q;
    assign mismatch  = (fifo_rd_data != pattern_word(burst_idx_q, exp_idx_q));

    tb_data_gen_fifo_chk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (wr_en),
        .wr_data (fifo_wr_data),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    state_d = (beats_in != '0 && times != '0) ? ST_GEN : ST_DONE;
                end
            end
            ST_GEN: begin
                if (wr_en && beat_idx_q == beats_q - 32'd1) begin
                    state_d = ST_WAIT_EMPTY;
                end
            end
            ST_WAIT_EMPTY: begin
                if (burst_end) begin
                    state_d = (burst_idx_q + 32'd1 == times_q) ? ST_DONE : ST_GEN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ap_idle      = (state_q == ST_IDLE);
        wr_en        = (state_q == ST_GEN) && !fifo_full;
        rd_en        = (state_q != ST_IDLE) && !fifo_empty && mask_q[phase_q];
        fifo_wr_data = pattern_word(burst_idx_q, beat_idx_q);
    end

    always_comb begin
        beats_d      = beats_q;
        times_d      = times_q;
        mask_d       = mask_q;
        burst_idx_d  = burst_idx_q;
        beat_idx_d   = beat_idx_q;
        exp_idx_d    = exp_idx_q;
        beat_count_d = beat_count_q;
        err_count_d  = err_count_q;
        first_err_d  = first_err_q;
        phase_d      = (state_q == ST_IDLE) ? 3'd0 : phase_q + 3'd1;
        rd_valid_d   = rd_en;
        ready_d      = start_acc;
        done_d       = (state_q == ST_DONE);

        if (start_acc) begin
            beats_d      = beats_in;
            times_d      = times;
            mask_d       = (drain_mask == 8'h00) ? MASK_ALL : drain_mask;
            burst_idx_d  = '0;
            beat_idx_d   = '0;
            exp_idx_d    = '0;
            beat_count_d = '0;
            err_count_d  = '0;
            first_err_d  = NO_ERR_BEAT;
        end
        if (wr_en) begin
            beat_idx_d = beat_idx_q + 32'd1;
        end
        if (rd_valid_q) begin
            beat_count_d = beat_count_q + 32'd1;
            exp_idx_d    = exp_idx_q + 32'd1;
            if (mismatch) begin
                if (err_count_q != ERR_SAT) begin
                    err_count_d = err_count_q + 16'd1;
                end
                // err_count never returns to zero mid-run, so it marks whether a mismatch was seen.
                if (err_count_q == '0) begin
                    first_err_d = beat_count_q;
                end
            end
        end
        if (state_q == ST_WAIT_EMPTY && burst_end) begin
            burst_idx_d = burst_idx_q + 32'd1;
            beat_idx_d  = '0;
            exp_idx_d   = '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beats_q      <= '0;
            times_q      <= '0;
            mask_q       <= MASK_ALL;
            burst_idx_q  <= '0;
            beat_idx_q   <= '0;
            exp_idx_q    <= '0;
            phase_q      <= '0;
            rd_valid_q   <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            beat_count_q <= '0;
            err_count_q  <= '0;
            first_err_q  <= NO_ERR_BEAT;
        end else begin
            beats_q      <= beats_d;
            times_q      <= times_d;
            mask_q       <= mask_d;
            burst_idx_q  <= burst_idx_d;
            beat_idx_q   <= beat_idx_d;
            exp_idx_q    <= exp_idx_d;
            phase_q      <= phase_d;
            rd_valid_q   <= rd_valid_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            beat_count_q <= beat_count_d;
            err_count_q  <= err_count_d;
            first_err_q  <= first_err_d;
        end
    end

    assign ap_ready       = ready_q;
    assign ap_done        = done_q;
    assign beat_count     = beat_count_q;
    assign err_count      = err_count_q;
    assign first_err_beat = first_err_q;

endmodule
